// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared FSM state encoding and default timing constants for
//               the debounce_pulse pushbutton conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Debounce FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Defaults sized for a 50 MHz clock
    localparam int DB_CYCLES_DEF     = 1000000;   // 20 ms stable level
    localparam int REPEAT_DELAY_DEF  = 25000000;  // 500 ms before first repeat
    localparam int REPEAT_PERIOD_DEF = 5000000;   // 100 ms between repeats

endpackage
`default_nettype wire

// File: rtl/debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse_if
// Description : Key-in / pulse-out bundle between the pushbutton conditioner
//               (slave) and the logic that drives and consumes it (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_pulse_if;
    logic key_n;   // raw pushbutton, active-low, may bounce
    logic pulse;   // one-cycle strobe per accepted press
    logic held;    // debounced press level

    modport master (output key_n, input pulse, input held);
    modport slave  (input key_n, output pulse, output held);
endinterface
`default_nettype wire

// File: rtl/debounce_pulse_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for an asynchronous single-bit input.
//               Both flops reset to 0 (the released key level).
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  wire  clk,
    input  wire  reset,
    input  wire  d,
    output logic q
);

    logic meta_q;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse
// Description : Pushbutton debouncer. Synchronizes the active-low key,
//               accepts a press/release only after DB_CYCLES stable cycles,
//               and emits a registered one-cycle pulse per accepted press.
//               Optional auto-repeat while held: define macro
//               DEBOUNCE_PULSE_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int CNT_W         = 20,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  wire              clk,
    input  wire              reset,
    debounce_pulse_if.slave  bus
);

    // Terminal count: the entry edge is counted as the first stable cycle
    localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pulse_q;
    logic              held_q;
    logic              key_s;

    // Key is active-low; invert so key_s=1 means pressed
    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (~bus.key_n),
        .q     (key_s)
    );

`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] C_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0]  rcnt_q;
    logic              rep_first_q;   // 1 until the first repeat has fired
    logic [CNT_W-1:0]  w_rep_last;

    assign w_rep_last = rep_first_q ? C_DELAY_LAST : C_PERIOD_LAST;
`else
    // Repeat timing is unused in this build; fold it into a named sink
    logic w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // Debounce FSM with registered pulse/held outputs; a level change always
    // wins over a counter reaching its terminal value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            held_q      <= 1'b0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
            rcnt_q      <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_s) begin
                        state_q <= DB_PRESS;
                        cnt_q   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!key_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == C_DB_LAST) begin
                        state_q <= PRESSED;
                        pulse_q <= 1'b1;
                        held_q  <= 1'b1;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
                        rcnt_q      <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!key_s) begin
                        state_q <= DB_RELEASE;
                        cnt_q   <= '0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
                        rcnt_q      <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
                    else if (rcnt_q == w_rep_last) begin
                        pulse_q     <= 1'b1;
                        rcnt_q      <= '0;
                        rep_first_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q + CNT_W'(1);
                    end
`endif
                end
                DB_RELEASE: begin
                    if (key_s) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == C_DB_LAST) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.held  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_pulse
// Description : Directed self-checking bench for debounce_pulse with
//               DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_pulse;

`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
    localparam bit C_REP = 1'b1;
`else
    localparam bit C_REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    debounce_pulse_if bus ();

    debounce_pulse #(
        .DB_CYCLES     (4),
        .CNT_W         (8),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.key_n = 1'b1;
        repeat (10) step();
        check("idle_held", 32'(bus.held), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        bus.key_n = 1'b1;

        // Reset asserted between edges must clear outputs with no clock
        #2 reset = 1'b1;
        #1;
        check("rst_pulse_noclk", 32'(bus.pulse), 32'd0);
        check("rst_held_noclk",  32'(bus.held),  32'd0);
        step();
        step();
        check("rst_pulse", 32'(bus.pulse),    32'd0);
        check("rst_held",  32'(bus.held),     32'd0);
        check("rst_state", 32'(dut.state_q),  32'd0);
        #2 reset = 1'b0;

        // Held press: pulse only after edge 6, held from edge 6 on
        bus.key_n = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("press_pulse_e%0d", e), 32'(bus.pulse), 32'(e == 6));
            check($sformatf("press_held_e%0d", e),  32'(bus.held),  32'(e >= 6));
        end

        // Release glitch while pressed: 2 cycles high then low again
        bus.key_n = 1'b1;
        step();
        step();
        bus.key_n = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("glitch_pulse_e%0d", e), 32'(bus.pulse), 32'd0);
            check($sformatf("glitch_held_e%0d", e),  32'(bus.held),  32'd1);
        end

        // Real release: held drops 6 edges after key_n goes high
        bus.key_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            step();
            check($sformatf("rel_held_e%0d", e), 32'(bus.held),  32'(e < 6));
            check($sformatf("rel_pulse_e%0d", e), 32'(bus.pulse), 32'd0);
        end

        // Short press, 3 cycles low: rejected
        bus.key_n = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (e == 2) bus.key_n = 1'b1;
            check($sformatf("short_pulse_e%0d", e), 32'(bus.pulse), 32'd0);
            check($sformatf("short_held_e%0d", e),  32'(bus.held),  32'd0);
        end

        // Bounce seen exactly at the terminal count edge: rejected
        bus.key_n = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (e == 3) bus.key_n = 1'b1;
            check($sformatf("term_pulse_e%0d", e), 32'(bus.pulse), 32'd0);
            check($sformatf("term_held_e%0d", e),  32'(bus.held),  32'd0);
        end
        go_idle();

        // Reset while pressed, key still held, then re-press after release
        bus.key_n = 1'b0;
        for (int e = 0; e < 7; e++) step();
        check("pre_rst_pulse", 32'(bus.pulse), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_pulse", 32'(bus.pulse), 32'd0);
        check("midrst_held",  32'(bus.held),  32'd0);
        step();
        check("inrst_held", 32'(bus.held), 32'd0);
        #2 reset = 1'b0;
        for (int e = 0; e < 9; e++) begin
            step();
            check($sformatf("rerst_pulse_e%0d", e), 32'(bus.pulse), 32'(e == 6));
            check($sformatf("rerst_held_e%0d", e),  32'(bus.held),  32'(e >= 6));
        end
        go_idle();

        // Long hold of 21 cycles: repeats at 14,17,20 only when enabled
        bus.key_n = 1'b0;
        for (int e = 0; e < 30; e++) begin
            step();
            if (e == 20) bus.key_n = 1'b1;
            check($sformatf("hold_pulse_e%0d", e), 32'(bus.pulse),
                  32'((e == 6) || (C_REP && (e == 14 || e == 17 || e == 20))));
            check($sformatf("hold_held_e%0d", e), 32'(bus.held),
                  32'((e >= 6) && (e < 27)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, giving the stable-level time in clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce and repeat counter width.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the hold time in cycles before the first auto-repeat.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 5000000, giving the spacing in cycles between auto-repeat pulses.
REQ-005 The block SHALL have port: clk  input  1  single system clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port: key_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
REQ-008 The block SHALL have port: pulse  output  1  one-cycle strobe per accepted press; drives the counter enable of the downstream counter stage.
REQ-009 The block SHALL have port: held  output  1  debounced press level.

Function
REQ-010 key_n SHALL pass through a two-flop synchronizer; the synchronized level key_s is the inverse of key_n after two edges.
REQ-011 The FSM SHALL have exactly four states: IDLE, DB_PRESS, PRESSED and DB_RELEASE.
REQ-012 In IDLE: key_s=1 -> DB_PRESS with cnt=0.
REQ-013 In DB_PRESS: key_s=1 and cnt<DB_CYCLES-1 -> cnt+1; key_s=0 -> IDLE with no pulse; key_s=1 and cnt==DB_CYCLES-1 -> PRESSED with pulse=1.
REQ-014 In PRESSED: key_s=0 -> DB_RELEASE with cnt=0.
REQ-015 In DB_RELEASE: key_s=1 -> PRESSED with no pulse; key_s=0 for DB_CYCLES consecutive cycles -> IDLE.
REQ-016 pulse SHALL be registered and high for exactly one cycle; if key_n is low before edge 0 and stays low, pulse SHALL rise on edge 2+DB_CYCLES and fall on the next edge.
REQ-017 held SHALL be 1 exactly in PRESSED and DB_RELEASE; it is registered and rises on the same edge as pulse.
REQ-018 Without repeat, at most one pulse SHALL be produced per accepted press, regardless of hold length.
REQ-019 The counters SHALL never wrap; DB_CYCLES SHALL satisfy 2 <= DB_CYCLES < 2^CNT_W, and REPEAT_DELAY and REPEAT_PERIOD SHALL be < 2^CNT_W when used.
REQ-020 A level change of key_s on the same edge that cnt reaches its terminal value SHALL take priority; the bounce is rejected.

Reset
REQ-021 reset=1 SHALL asynchronously force state=IDLE, cnt=0, both synchronizer flops to the released value (0), pulse=0 and held=0.
REQ-022 On release of reset with the key still held, the key SHALL be treated as a new press, producing a pulse after 2+DB_CYCLES edges.

Configuration
REQ-023 With macro DEBOUNCE_PULSE_AUTO_REPEAT_EN defined, in PRESSED the block SHALL emit a pulse REPEAT_DELAY edges after the debounce pulse and then every REPEAT_PERIOD edges while it stays in PRESSED.
REQ-024 The repeat counter SHALL be cleared on entry to DB_RELEASE.
REQ-025 Without the macro, no repeat counter SHALL be synthesized, REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and REQ-018 applies.

Structure
REQ-026 Package debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and default constants DB_CYCLES_DEF, REPEAT_DELAY_DEF and REPEAT_PERIOD_DEF.
REQ-027 The synchronizer SHALL be the single sub-module sync2 (clk, reset, d, q), with 2 flops and reset to 0.

Verification (DB_CYCLES=4)
REQ-028 Scenario: reset=1, key_n=1 -> pulse=0, held=0, state IDLE; apply reset mid-cycle -> outputs clear without a clk edge.
REQ-029 Scenario: key_n low before edge 0 and held -> pulse=1 only after edge 6, held=1 from edge 6 onward.
REQ-030 Scenario: key_n low for 3 cycles then high -> no pulse, held stays 0.
REQ-031 Scenario: while PRESSED, key_n high 2 cycles then low -> no second pulse, held stays 1; then key_n high 6 cycles -> held=0.
REQ-032 Scenario: reset pulsed in PRESSED with key held -> pulse=0, held=0 immediately; after reset release, a pulse occurs 6 edges later.
REQ-033 Scenario: macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=3, key held 21 cycles -> pulses after edges 6, 14, 17 and 20 only.
